// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch front end.
// Imported by the fetch unit and its response FIFO.
package fetch_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Response buffer between program memory and decode: {pc, instr} entries.
// Flush wins over push and pop; pointers wrap modulo DEPTH.
module fetch_fifo #(
   parameter int DW    = 64,
   parameter int DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   input  logic [DW-1:0]          data_i,
   output logic [DW-1:0]          data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [AW:0]   cnt_q;
   logic          do_push;
   logic          do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign count_o = cnt_q;
   assign data_o  = mem_q[rd_q];
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Storage needs no reset: contents are only visible behind count.
   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) mem_q[wr_q] <= data_i;
   end

   a_no_overflow: assert property (
      @(posedge clk_i) disable iff (rst_i) !(push_i && full_o)
   );

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited requests to program memory,
// in-order response buffering and redirect with stale-response draining.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter int               DEPTH    = 4,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   output logic             imem_req_o,
   output logic [WIDTH-1:0] imem_addr_o,
   input  logic             imem_gnt_i,
   input  logic             imem_rvalid_i,
   input  logic [WIDTH-1:0] imem_rdata_i,
   input  logic             redirect_i,
   input  logic [WIDTH-1:0] redirect_pc_i,
   input  logic             id_ready_i,
   output logic             id_valid_o,
   output logic [WIDTH-1:0] id_instr_o,
   output logic [WIDTH-1:0] id_pc_o
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t       state_q, state_d;
   logic [WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
   logic [WIDTH-1:0]   resp_pc_q, resp_pc_d;
   logic [WIDTH-1:0]   new_pc;
   logic [CW-1:0]      outst_q, outst_d;
   logic [CW-1:0]      discard_q, discard_d;
   logic [CW-1:0]      redir_cnt;
   logic [CW-1:0]      fifo_cnt;
   logic               fifo_full;
   logic               fifo_empty;
   logic [2*WIDTH-1:0] fifo_rdata;
   logic               redir;
   logic               grant;
   logic               rsp_live;
   logic               credit_ok;
   logic               push;
   logic               pop;

   assign redir     = redirect_i && (state_q != IDLE);
   assign credit_ok = ({1'b0, fifo_cnt} + {1'b0, outst_q})
                      < (CW+1)'(DEPTH);

   assign imem_req_o  = (state_q == FETCH) && !redirect_i && credit_ok;
   assign imem_addr_o = fetch_pc_q;
   assign grant       = imem_req_o && imem_gnt_i;

   // A response with nothing outstanding belongs to a pre-reset request.
   assign rsp_live  = imem_rvalid_i && (outst_q != '0);
   assign redir_cnt = outst_q - CW'(rsp_live);
   assign new_pc    = {redirect_pc_i[WIDTH-1:2], 2'b00};

   assign push = (state_q == FETCH) && !redir && rsp_live;

   assign id_valid_o = !fifo_empty && !redirect_i;
   assign pop        = id_valid_o && id_ready_i;
   assign id_pc_o    = id_valid_o ? fifo_rdata[2*WIDTH-1:WIDTH] : '0;
   assign id_instr_o = id_valid_o ? fifo_rdata[WIDTH-1:0]
                                  : WIDTH'(NOP_INSTR);

   fetch_fifo #(
      .DW    (2*WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (redir),
      .data_i  ({resp_pc_q, imem_rdata_i}),
      .data_o  (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      outst_d    = outst_q;
      discard_d  = discard_q;
      if (redir) begin
         fetch_pc_d = new_pc;
         resp_pc_d  = new_pc;
         outst_d    = redir_cnt;
         discard_d  = redir_cnt;
         state_d    = (redir_cnt != '0) ? DRAIN : FETCH;
      end else begin
         unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
               if (grant) fetch_pc_d = fetch_pc_q + WIDTH'(4);
               if (push)  resp_pc_d  = resp_pc_q + WIDTH'(4);
               outst_d = outst_q + CW'(grant) - CW'(rsp_live);
            end
            DRAIN: begin
               if (rsp_live) begin
                  discard_d = discard_q - 1'b1;
                  outst_d   = outst_q - 1'b1;
                  if (discard_q == CW'(1)) state_d = FETCH;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         outst_q    <= '0;
         discard_q  <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         outst_q    <= outst_d;
         discard_q  <= discard_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model, expected-stream scoreboard
// and directed scenarios with literal expectations.
module tb_fetch_unit;

   localparam int          WIDTH    = 32;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        id_ready = 1'b0;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;

   fetch_unit #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .imem_req_o    (imem_req),
      .imem_addr_o   (imem_addr),
      .imem_gnt_i    (imem_gnt),
      .imem_rvalid_i (imem_rvalid),
      .imem_rdata_i  (imem_rdata),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .id_ready_i    (id_ready),
      .id_valid_o    (id_valid),
      .id_instr_o    (id_instr),
      .id_pc_o       (id_pc)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] word(logic [31:0] a);
      return {a[15:0] ^ 16'hC0DE, a[15:0]};
   endfunction

   // stimulus knobs
   bit          gnt_en = 1'b1;
   bit          ready_k = 1'b1;
   bit          hold = 1'b0;
   int          lat = 1;
   int          hold_at = -1;
   logic [31:0] stall_addr = 32'h0;
   int          stall_n = 0;
   int          stall_seen = 0;
   bit          r1_arm = 1'b0;
   bit          r2_arm = 1'b0;
   int          r1_n = 0;
   logic [31:0] r1_pc = 32'h0;
   logic [31:0] r2_pc = 32'h0;

   // memory: kind 0 live, 1 stale by redirect, 2 stale by reset
   logic [31:0] q_addr[$];
   int          q_due[$];
   int          q_kind[$];

   // expected-stream model and observations
   int          cyc = 0;
   logic [31:0] exp_pc = RESET_PC;
   logic [31:0] exp_ga = RESET_PC;
   int          live = 0;
   int          n_grant = 0;
   int          n_pop = 0;
   int          n_deliv = 0;
   logic [31:0] grant_log[16];
   logic [31:0] pop_log[16];
   bit          got_v = 1'b0;
   bit          got_g = 1'b0;
   logic [31:0] first_vpc = 32'hFFFF_FFFF;
   logic [31:0] first_ga = 32'hFFFF_FFFF;
   bit          seen40 = 1'b0;
   bit          prev_pend = 1'b0;
   logic [31:0] prev_addr = 32'h0;

   always @(negedge clk) begin
      bit          rv;
      bit          rd;
      bit          st;
      int          rk;
      int          k0;
      int          k1;
      logic [31:0] ra;
      cyc++;
      rv = 1'b0;
      rd = 1'b0;
      rk = 0;
      ra = 32'h0;
      if (rst) begin
         if (!hold) begin
            q_addr.delete();
            q_due.delete();
            q_kind.delete();
         end
         foreach (q_kind[i]) q_kind[i] = 2;
         imem_rvalid = 1'b0;
         imem_rdata  = 32'hDEAD_BEEF;
         imem_gnt    = 1'b0;
         redirect    = 1'b0;
         id_ready    = ready_k;
         exp_pc      = RESET_PC;
         exp_ga      = RESET_PC;
         live        = 0;
         n_grant     = 0;
         n_pop       = 0;
         n_deliv     = 0;
         got_v       = 1'b0;
         got_g       = 1'b0;
         prev_pend   = 1'b0;
      end else begin
         k0 = 0;
         foreach (q_kind[i]) if (q_kind[i] == 0) k0++;
         if (!hold && q_due.size() > 0 && q_due[0] <= cyc) begin
            rv = 1'b1;
            ra = q_addr.pop_front();
            rk = q_kind.pop_front();
            void'(q_due.pop_front());
         end
         if (rv && rk == 0) begin
            n_deliv++;
            if (n_deliv == hold_at) begin
               hold    = 1'b1;
               hold_at = -1;
            end
         end
         k1 = 0;
         foreach (q_kind[i]) if (q_kind[i] == 1) k1++;
         st = (k1 > 0) || (rv && rk == 1);
         if (r1_arm && k0 == r1_n) begin
            rd = 1'b1;
            r1_arm = 1'b0;
            redirect_pc = r1_pc;
         end else if (r2_arm && !r1_arm && k1 > 0) begin
            rd = 1'b1;
            r2_arm = 1'b0;
            redirect_pc = r2_pc;
         end
         redirect    = rd;
         imem_rvalid = rv;
         imem_rdata  = rv ? word(ra) : 32'hDEAD_BEEF;
         id_ready    = ready_k;
         if (rd) begin
            foreach (q_kind[i]) q_kind[i] = 1;
            exp_pc = {redirect_pc[31:2], 2'b00};
            exp_ga = exp_pc;
            live   = 0;
            got_v  = 1'b0;
            got_g  = 1'b0;
         end
         #1;
         imem_gnt = gnt_en;
         if (gnt_en && stall_n > 0 && imem_req && imem_addr == stall_addr) begin
            imem_gnt = 1'b0;
            stall_n--;
            stall_seen++;
         end
         #1;
         chk("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
         if (rd) begin
            chk("redir_valid", {31'b0, id_valid}, 32'h0);
            chk("redir_req", {31'b0, imem_req}, 32'h0);
         end
         if (st) chk("drain_req", {31'b0, imem_req}, 32'h0);
         if (prev_pend && !rd) begin
            chk("hold_req", {31'b0, imem_req}, 32'h1);
            chk("hold_addr", imem_addr, prev_addr);
         end
         if (imem_req) begin
            chk("req_addr", imem_addr, exp_ga);
            chk("credit", {31'b0, live < DEPTH}, 32'h1);
         end
         if (id_valid) begin
            chk("id_pc", id_pc, exp_pc);
            chk("id_instr", id_instr, word(exp_pc));
         end else begin
            chk("idle_instr", id_instr, NOP);
            chk("idle_pc", id_pc, 32'h0);
         end
         if (imem_req && imem_gnt) begin
            q_addr.push_back(imem_addr);
            q_due.push_back(cyc + lat);
            q_kind.push_back(0);
            if (n_grant < 16) grant_log[n_grant] = imem_addr;
            n_grant++;
            exp_ga = exp_ga + 32'd4;
            live++;
            if (!got_g) begin
               got_g    = 1'b1;
               first_ga = imem_addr;
            end
         end
         if (id_valid) begin
            if (!got_v) begin
               got_v     = 1'b1;
               first_vpc = id_pc;
            end
            if (id_pc == 32'h40) seen40 = 1'b1;
         end
         if (id_valid && id_ready) begin
            if (n_pop < 16) pop_log[n_pop] = id_pc;
            n_pop++;
            exp_pc = exp_pc + 32'd4;
            live--;
         end
         prev_pend = imem_req && !imem_gnt;
         prev_addr = imem_addr;
      end
   end

   task automatic cycles(int n);
      repeat (n) @(negedge clk);
      #3;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic chk_reset_vals(string tag);
      chk({tag, "_req"}, {31'b0, imem_req}, 32'h0);
      chk({tag, "_addr"}, imem_addr, RESET_PC);
      chk({tag, "_valid"}, {31'b0, id_valid}, 32'h0);
      chk({tag, "_instr"}, id_instr, NOP);
      chk({tag, "_pc"}, id_pc, 32'h0);
   endtask

   initial begin
      int first;
      int p0;

      // streaming with single-cycle memory
      gnt_en  = 1'b1;
      ready_k = 1'b1;
      lat     = 1;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk_reset_vals("rst");
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      first = -1;
      for (int k = 0; k < 12 && first < 0; k++) begin
         cycles(1);
         if (id_valid) first = k;
      end
      chk("first_valid_edges", first, 32'd3);
      chk("first_pc", id_pc, 32'h0);
      p0 = n_pop;
      cycles(8);
      chk("throughput", n_pop - p0, 32'd8);

      // decode stalled: credit limit, then in-order drain
      ready_k = 1'b0;
      do_reset();
      cycles(12);
      chk("grants_stalled", n_grant, 32'd4);
      chk("req_blocked", {31'b0, imem_req}, 32'h0);
      chk("last_grant", grant_log[3], 32'hC);
      ready_k = 1'b1;
      cycles(10);
      for (int i = 0; i < 4; i++) chk("pop_order", pop_log[i], 32'(i * 4));
      chk("resume_addr", grant_log[4], 32'h10);

      // grant withheld for five cycles at 0x8
      stall_addr = 32'h8;
      stall_n    = 5;
      stall_seen = 0;
      do_reset();
      cycles(15);
      chk("stall_cycles", stall_seen, 32'd5);
      chk("grant_at_8", grant_log[2], 32'h8);
      chk("grant_after_8", grant_log[3], 32'hC);

      // redirect with two in flight
      lat   = 3;
      r1_n  = 2;
      r1_pc = 32'h43;
      do_reset();
      r1_arm = 1'b1;
      cycles(25);
      chk("redir1_fired", {31'b0, r1_arm}, 32'h0);
      chk("redir1_got", {30'b0, got_g, got_v}, 32'h3);
      chk("redir1_grant", first_ga, 32'h40);
      chk("redir1_pc", first_vpc, 32'h40);

      // second redirect while draining
      lat    = 4;
      seen40 = 1'b0;
      r1_n   = 3;
      r1_pc  = 32'h43;
      r2_pc  = 32'h80;
      do_reset();
      r1_arm = 1'b1;
      r2_arm = 1'b1;
      cycles(30);
      chk("redir2_fired", {31'b0, r2_arm}, 32'h0);
      chk("redir2_grant", first_ga, 32'h80);
      chk("redir2_pc", first_vpc, 32'h80);
      chk("no_0x40", {31'b0, seen40}, 32'h0);

      // async reset with three buffered and one in flight
      lat     = 1;
      ready_k = 1'b0;
      hold_at = 3;
      do_reset();
      for (int k = 0; k < 20 && !hold; k++) cycles(1);
      chk("hold_reached", {31'b0, hold}, 32'h1);
      cycles(2);
      chk("pre_rst_valid", {31'b0, id_valid}, 32'h1);
      chk("pre_rst_pc", id_pc, 32'h0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk_reset_vals("async");
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      ready_k = 1'b1;
      @(posedge clk);
      #2 hold = 1'b0;
      cycles(12);
      chk("rst_first_pc", first_vpc, RESET_PC);
      chk("rst_pops", {31'b0, n_pop > 4}, 32'h1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
